// File: rtl/boot_load_sequencer.sv
// boot_load_sequencer: system bring-up sequencer and owner of the main-memory request port.
// The sequencer walks RESET -> MEM_WAIT -> LOAD -> RUN. During LOAD it turns the SD loader's
// word handshake into addressed memory writes. In RUN it bridges single CPU accesses to memory.
// Optional feature: define BOOT_TIMEOUT_EN to enable the loader idle timeout (TIMEOUT_CYC).
// When that macro is undefined there is no idle counter, boot_err_o is tied low and LOAD
// waits indefinitely.
module boot_load_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] BIN_SIZE  = 32'h0001_0000,
    parameter int unsigned RST_HOLD  = 16
`ifdef BOOT_TIMEOUT_EN
    ,
    parameter logic [31:0] TIMEOUT_CYC = 32'd27_000_000
`endif
) (
    input  logic        clk27mhz,
    input  logic        resetn,
    input  logic        mem_calib_done_i,
    input  logic        ld_we_i,
    input  logic [31:0] ld_data_i,
    input  logic        ld_done_i,
    output logic [2:0]  main_init_state_o,
    output logic [7:0]  ctrl_state_o,
    output logic        cpu_rstn_o,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic [3:0]  cpu_be_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_ack_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic [31:0] words_loaded_o,
    output logic        load_ovf_o,
    output logic        boot_err_o
);

    typedef enum logic [2:0] {
        StReset   = 3'd0,
        StMemWait = 3'd1,
        StLoad    = 3'd3,
        StRun     = 3'd4,
        StErr     = 3'd7
    } init_state_e;

    typedef enum logic [7:0] {
        CtrlIdle     = 8'd0,
        CtrlIssue    = 8'd1,
        CtrlComplete = 8'd2
    } ctrl_state_e;

    // Number of words that fit in the image; mem_addr saturates at BASE_ADDR + BIN_SIZE.
    localparam logic [31:0] WordLimit = BIN_SIZE >> 2;

    init_state_e state_q;
    ctrl_state_e ctrl_q;
    logic [31:0] hold_cnt_q;
    logic        cpu_rstn_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_be_q;
    logic        cpu_ack_q;
    logic [31:0] cpu_rdata_q;
    logic [31:0] words_q;
    logic        ovf_q;
`ifdef BOOT_TIMEOUT_EN
    logic [31:0] idle_cnt_q;
    logic        boot_err_q;
`endif

    // Init FSM, loader handshake and CPU bridge; all outputs are registered here.
    always_ff @(posedge clk27mhz) begin
        if (!resetn) begin
            state_q     <= StReset;
            ctrl_q      <= CtrlIdle;
            hold_cnt_q  <= '0;
            cpu_rstn_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            words_q     <= '0;
            ovf_q       <= 1'b0;
`ifdef BOOT_TIMEOUT_EN
            idle_cnt_q  <= '0;
            boot_err_q  <= 1'b0;
`endif
        end else begin
            cpu_ack_q  <= 1'b0;
            // Released one cycle after RUN is entered, never from ERR.
            cpu_rstn_q <= (state_q == StRun);

            case (state_q)
                StReset: begin
                    if (hold_cnt_q + 32'd1 >= RST_HOLD) begin
                        state_q <= StMemWait;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 32'd1;
                    end
                end

                StMemWait: begin
                    if (mem_calib_done_i) begin
                        state_q <= StLoad;
`ifdef BOOT_TIMEOUT_EN
                        idle_cnt_q <= '0;
`endif
                    end
                end

                StLoad: begin
                    case (ctrl_q)
                        CtrlIdle: begin
                            // A pending word always wins over ld_done so it is written first.
                            if (ld_we_i) begin
                                if (words_q == WordLimit) begin
                                    ovf_q  <= 1'b1;
                                    ctrl_q <= CtrlComplete;
                                end else begin
                                    mem_wdata_q <= ld_data_i;
                                    mem_req_q   <= 1'b1;
                                    mem_we_q    <= 1'b1;
                                    mem_be_q    <= 4'hF;
                                    ctrl_q      <= CtrlIssue;
                                end
`ifdef BOOT_TIMEOUT_EN
                                idle_cnt_q <= '0;
`endif
                            end else if (ld_done_i) begin
                                state_q <= StRun;
                            end
`ifdef BOOT_TIMEOUT_EN
                            else if (idle_cnt_q + 32'd1 >= TIMEOUT_CYC) begin
                                state_q    <= StErr;
                                boot_err_q <= 1'b1;
                            end else begin
                                idle_cnt_q <= idle_cnt_q + 32'd1;
                            end
`endif
                        end
                        CtrlIssue: begin
                            if (mem_ack_i) begin
                                mem_req_q  <= 1'b0;
                                mem_addr_q <= mem_addr_q + 32'd4;
                                words_q    <= words_q + 32'd1;
                                ctrl_q     <= CtrlComplete;
                            end
                        end
                        CtrlComplete: begin
                            // Wait for the loader to drop its level so one word = one write.
                            if (!ld_we_i) begin
                                ctrl_q <= CtrlIdle;
                            end
                        end
                        default: ctrl_q <= CtrlIdle;
                    endcase
                end

                StRun: begin
                    if (mem_req_q) begin
                        if (mem_ack_i) begin
                            mem_req_q   <= 1'b0;
                            cpu_rdata_q <= mem_rdata_i;
                            cpu_ack_q   <= 1'b1;
                        end
                    end else if (cpu_req_i && !cpu_ack_q) begin
                        // Requester still holds req during the ack cycle; do not re-issue it.
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= cpu_we_i;
                        mem_addr_q  <= cpu_addr_i;
                        mem_wdata_q <= cpu_wdata_i;
                        mem_be_q    <= cpu_be_i;
                    end
                end

                StErr: begin
                    state_q <= StErr;
                end

                default: state_q <= StReset;
            endcase
        end
    end

    assign main_init_state_o = state_q;
    assign ctrl_state_o      = ctrl_q;
    assign cpu_rstn_o        = cpu_rstn_q;
    assign mem_req_o         = mem_req_q;
    assign mem_we_o          = mem_we_q;
    assign mem_addr_o        = mem_addr_q;
    assign mem_wdata_o       = mem_wdata_q;
    assign mem_be_o          = mem_be_q;
    assign cpu_ack_o         = cpu_ack_q;
    assign cpu_rdata_o       = cpu_rdata_q;
    assign words_loaded_o    = words_q;
    assign load_ovf_o        = ovf_q;
`ifdef BOOT_TIMEOUT_EN
    assign boot_err_o        = boot_err_q;
`else
    assign boot_err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_boot_load_sequencer.sv
// tb_boot_load_sequencer: directed + randomized bench for boot_load_sequencer.
// Expected values come from a word-count model of the boot image (base + 4 * words accepted,
// saturating at the image limit) and from the CPU transactions the bench itself issues.
module tb_boot_load_sequencer;

    localparam logic [31:0] Base    = 32'h0000_0200;
    localparam logic [31:0] BinSize = 32'd24;
    localparam int unsigned Limit   = 6;
    localparam int unsigned RstHold = 6;

    logic        clk27mhz = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_calib_done = 1'b0;
    logic        ld_we = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_done = 1'b0;
    logic [2:0]  main_init_state;
    logic [7:0]  ctrl_state;
    logic        cpu_rstn;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_be = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] words_loaded;
    logic        load_ovf;
    logic        boot_err;

    int compared = 0;
    int mismatched = 0;
    int n_sent = 0;   // loader words offered since the last reset

    boot_load_sequencer #(
        .BASE_ADDR (Base),
        .BIN_SIZE  (BinSize),
        .RST_HOLD  (RstHold)
`ifdef BOOT_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (32'd100)
`endif
    ) dut (
        .clk27mhz          (clk27mhz),
        .resetn            (resetn),
        .mem_calib_done_i  (mem_calib_done),
        .ld_we_i           (ld_we),
        .ld_data_i         (ld_data),
        .ld_done_i         (ld_done),
        .main_init_state_o (main_init_state),
        .ctrl_state_o      (ctrl_state),
        .cpu_rstn_o        (cpu_rstn),
        .cpu_req_i         (cpu_req),
        .cpu_we_i          (cpu_we),
        .cpu_addr_i        (cpu_addr),
        .cpu_wdata_i       (cpu_wdata),
        .cpu_be_i          (cpu_be),
        .cpu_rdata_o       (cpu_rdata),
        .cpu_ack_o         (cpu_ack),
        .mem_req_o         (mem_req),
        .mem_we_o          (mem_we),
        .mem_addr_o        (mem_addr),
        .mem_wdata_o       (mem_wdata),
        .mem_be_o          (mem_be),
        .mem_rdata_i       (mem_rdata),
        .mem_ack_i         (mem_ack),
        .words_loaded_o    (words_loaded),
        .load_ovf_o        (load_ovf),
        .boot_err_o        (boot_err)
    );

    always #18 clk27mhz = ~clk27mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk27mhz);
        #1;
    endtask

    function automatic int model_words();
        return (n_sent < Limit) ? n_sent : Limit;
    endfunction

    task automatic check_reset_values();
        chk("rst_state", 32'(main_init_state), 32'd0);
        chk("rst_ctrl", 32'(ctrl_state), 32'd0);
        chk("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
        chk("rst_mem_req_we", 32'({mem_req, mem_we}), 32'd0);
        chk("rst_mem_addr", mem_addr, Base);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_words", words_loaded, 32'd0);
        chk("rst_ovf_err", 32'({load_ovf, boot_err}), 32'd0);
    endtask

    // Reset, release, wait for MEM_WAIT, hold calibration off for calib_dly cycles, enter LOAD.
    task automatic bring_up(input int calib_dly);
        int cyc;
        resetn = 1'b0;
        mem_calib_done = 1'b0;
        ld_we = 1'b0;
        ld_done = 1'b0;
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        repeat (3) tick();
        n_sent = 0;
        check_reset_values();
        resetn = 1'b1;
        cyc = 0;
        while (main_init_state != 3'd1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("rst_hold_len", 32'(cyc), 32'(RstHold));
        cpu_req = 1'b1;
        cpu_addr = 32'h0000_0040;
        repeat (calib_dly) tick();
        chk("memwait_state", 32'(main_init_state), 32'd1);
        chk("memwait_no_req", 32'(mem_req), 32'd0);
        mem_calib_done = 1'b1;
        tick();
        chk("load_entry", 32'(main_init_state), 32'd3);
        tick();
        chk("load_cpu_req_ignored", 32'(mem_req), 32'd0);
        chk("load_cpu_rstn_low", 32'(cpu_rstn), 32'd0);
        cpu_req = 1'b0;
    endtask

    // One loader word: handshake through ISSUE (if under the limit) and COMPLETE.
    task automatic send_word(input logic [31:0] d, input int ack_dly, input int hold_extra);
        ld_we = 1'b1;
        ld_data = d;
        tick();
        chk("ld_state_load", 32'(main_init_state), 32'd3);
        if (n_sent < Limit) begin
            chk("ld_mem_req", 32'(mem_req), 32'd1);
            chk("ld_ctrl_issue", 32'(ctrl_state), 32'd1);
            chk("ld_wdata", mem_wdata, d);
            chk("ld_addr", mem_addr, Base + 32'(4 * n_sent));
            chk("ld_we_be", 32'({mem_we, mem_be}), 32'h1F);
            for (int i = 0; i < ack_dly; i++) begin
                tick();
                chk("ld_wait_req", 32'({ctrl_state, mem_req}), 32'h003);
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            chk("ld_req_drop", 32'(mem_req), 32'd0);
        end
        n_sent++;
        chk("ld_ctrl_complete", 32'(ctrl_state), 32'd2);
        chk("ld_words", words_loaded, 32'(model_words()));
        chk("ld_addr_next", mem_addr, Base + 32'(4 * model_words()));
        chk("ld_ovf", 32'(load_ovf), (n_sent > Limit) ? 32'd1 : 32'd0);
        for (int i = 0; i < hold_extra; i++) begin
            tick();
            chk("ld_hold_no_rewrite", 32'({ctrl_state, mem_req}), 32'h004);
        end
        ld_we = 1'b0;
        tick();
        chk("ld_back_idle", 32'(ctrl_state), 32'd0);
        chk("ld_words_stable", words_loaded, 32'(model_words()));
    endtask

    task automatic finish_to_run();
        ld_done = 1'b1;
        tick();
        chk("run_entry", 32'(main_init_state), 32'd4);
        chk("run_cpu_rstn_lag", 32'(cpu_rstn), 32'd0);
        tick();
        chk("run_cpu_rstn", 32'(cpu_rstn), 32'd1);
        ld_done = 1'b0;
        chk("run_boot_err", 32'(boot_err), 32'd0);
    endtask

    task automatic cpu_access(input logic [31:0] a, input logic w, input logic [31:0] wd,
                              input logic [3:0] be, input int dly, input logic [31:0] rd);
        cpu_req = 1'b1;
        cpu_addr = a;
        cpu_we = w;
        cpu_wdata = wd;
        cpu_be = be;
        tick();
        chk("cpu_mem_req", 32'(mem_req), 32'd1);
        chk("cpu_mem_addr", mem_addr, a);
        chk("cpu_mem_we_be", 32'({mem_we, mem_be}), 32'({w, be}));
        chk("cpu_mem_wdata", mem_wdata, wd);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("cpu_wait", 32'({mem_req, cpu_ack}), 32'h2);
        end
        mem_ack = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack = 1'b0;
        mem_rdata = $urandom();
        chk("cpu_ack_pulse", 32'({mem_req, cpu_ack}), 32'h1);
        chk("cpu_rdata", cpu_rdata, rd);
        tick();
        chk("cpu_ack_one_cycle", 32'({mem_req, cpu_ack}), 32'h0);
        chk("cpu_rdata_hold", cpu_rdata, rd);
        cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] pat [4];
        int nw;
        pat[0] = 32'h1122_3344;
        pat[1] = 32'h5566_7788;
        pat[2] = 32'h99AA_BBCC;
        pat[3] = 32'hDDEE_FF00;

        // Boot 1: directed pattern words, then fill to the limit and overflow twice.
        bring_up(21);
        for (int i = 0; i < 4; i++) send_word(pat[i], $urandom_range(0, 3), $urandom_range(0, 2));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_words", words_loaded, 32'd4);
        chk("stray_ack_ctrl", 32'(ctrl_state), 32'd0);
        send_word($urandom(), 10, 20);
        send_word($urandom(), $urandom_range(0, 3), 0);
        send_word($urandom(), 0, 3);
        chk("limit_addr", mem_addr, Base + BinSize);
        send_word($urandom(), 0, 0);
        finish_to_run();

        // RUN: directed read then random accesses.
        cpu_access(32'h0000_0100, 1'b0, 32'h0, 4'hF, 3, 32'hDEAD_BEEF);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("run_stray_ack", 32'({mem_req, cpu_ack}), 32'h0);
        for (int i = 0; i < 6; i++) begin
            cpu_access($urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom(),
                       4'($urandom_range(1, 15)), $urandom_range(0, 4), $urandom());
        end

        // Reset while a loader write is in flight.
        bring_up(2);
        ld_we = 1'b1;
        ld_data = 32'hCAFE_F00D;
        tick();
        chk("midrst_issue", 32'(ctrl_state), 32'd1);
        resetn = 1'b0;
        tick();
        ld_we = 1'b0;
        n_sent = 0;
        check_reset_values();

        // Boot 3: random count under the limit, last word arrives together with ld_done.
        bring_up($urandom_range(0, 5));
        nw = $urandom_range(1, 5);
        for (int i = 0; i < nw - 1; i++) send_word($urandom(), $urandom_range(0, 4), $urandom_range(0, 3));
        ld_done = 1'b1;
        send_word($urandom(), $urandom_range(0, 4), $urandom_range(0, 3));
        chk("done_with_word", words_loaded, 32'(nw));
        finish_to_run();
        cpu_access($urandom() & 32'hFFFF_FFFC, 1'b1, $urandom(), 4'h3, 1, $urandom());

        // Boot 4: random count beyond the limit.
        bring_up(1);
        nw = $urandom_range(7, 9);
        for (int i = 0; i < nw; i++) send_word($urandom(), $urandom_range(0, 2), $urandom_range(0, 2));
        chk("ovf_sticky", 32'(load_ovf), 32'd1);
        finish_to_run();

`ifdef BOOT_TIMEOUT_EN
        // Idle timeout: one idle LOAD cycle already elapsed inside bring_up.
        bring_up(0);
        repeat (98) tick();
        chk("to_not_yet", 32'(main_init_state), 32'd3);
        tick();
        chk("to_state_err", 32'(main_init_state), 32'd7);
        chk("to_boot_err", 32'(boot_err), 32'd1);
        ld_done = 1'b1;
        repeat (3) tick();
        chk("to_terminal", 32'({main_init_state, cpu_rstn, mem_req}), 32'h1C);
        ld_done = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
